munoc_ahb_slave_network_interface_core: RTL and testbench
=========================================================

Name: munoc_ahb_slave_network_interface_core

Overview:
- NoC-side endpoint that drives an AHB-Lite slave; the counterpart of the AHB master network interface.
- Accepts single-beat read/write requests, already depacketised from the forward NI link, and performs one AHB SINGLE transfer per request.
- Returns a response with data, transaction ID and AXI-style status toward the backward NI packetiser.
- Single outstanding transaction; all AHB outputs are registered.

Parameters:
- BW_PLATFORM_ADDR, 32, address width.
- BW_NODE_DATA, 32, data width; one of 32/64/128.
- BW_TID, 4, transaction ID width, carried opaquely.
- BW_ERRCNT, 8, error counter width (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- comm_disable  in  1  blocks acceptance of new requests
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready
- req_write  in  1  1=write
- req_addr  in  BW_PLATFORM_ADDR  byte address
- req_size  in  3  AXI/AHB size code
- req_prot  in  4  HPROT value
- req_tid  in  BW_TID  transaction ID
- req_wdata  in  BW_NODE_DATA  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when valid&ready
- rsp_write  out  1  echo of req_write
- rsp_tid  out  BW_TID  echo of req_tid
- rsp_rdata  out  BW_NODE_DATA  read data; 0 for writes and errors
- rsp_resp  out  2  0=OKAY, 2=SLVERR
- shaddr  out  BW_PLATFORM_ADDR  HADDR
- shburst  out  3  HBURST, constant 0 (SINGLE)
- shmasterlock  out  1  constant 0
- shprot  out  4  HPROT
- shsize  out  3  HSIZE
- shtrans  out  2  HTRANS
- shwdata  out  BW_NODE_DATA  HWDATA
- shwrite  out  1  HWRITE
- shrdata  in  BW_NODE_DATA  HRDATA
- shready  in  1  HREADY
- shresp  in  1  HRESP
- err_count  out  BW_ERRCNT  optional feature only

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; req_ready=0; rsp_valid=0; shtrans=IDLE(0); shaddr, shwdata, shwrite, shsize, shprot, rsp_* all 0. Reset aborts any in-flight transfer without a response.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - req_ready = !comm_disable (combinational from state and comm_disable).
  - On accept, latch all req fields.
  - If req_size > log2(BW_NODE_DATA/8): go to RESP with SLVERR and no AHB activity.
  - Otherwise go to ADDR. Registered outputs give shtrans=NONSEQ(2), with shaddr/shsize/shprot/shwrite valid, in the first ADDR cycle.
- ADDR:
  - Hold address-phase signals.
  - On shready=1, go to DATA. Next cycle: shtrans=IDLE; shwdata=latched wdata for writes, 0 for reads.
- DATA:
  - Hold shwdata until shready=1.
  - At shready=1: capture shrdata (reads with shresp=0 only), set resp = shresp ? SLVERR : OKAY, then go to RESP.
  - Two-cycle AHB error: shresp=1 with shready=0 is a wait cycle; the error is recorded only on the shready=1 cycle.
- RESP:
  - rsp_valid=1; hold all rsp_* stable until rsp_ready=1, then go to IDLE.
  - req_ready is 0 in RESP; there is no same-cycle re-accept.
- Minimum latency from request accept to rsp_valid, with shready=1 throughout: 3 cycles.
  - Accept edge E0; ADDR at E0+1; DATA at E0+2; rsp_valid high from E0+3.
- comm_disable:
  - Affects IDLE acceptance only; an in-flight transaction completes normally.
  - Asserted in the same cycle as req_valid in IDLE: no accept.
- Address alignment is not checked; the address is forwarded unchanged.

Optional Feature:
- Macro: MUNOC_AHB_SLAVE_NI_ERROR_COUNT_EN.
- Defined: err_count increments by 1 on every response issued with SLVERR (size error or AHB error), at the rsp_valid&rsp_ready edge.
  - Saturates at all-ones.
  - Reset to 0.
- Undefined: err_count is tied to 0 and no counter flops are generated.

Decomposition:
- Shared header munoc_ahb_slave_ni.vh holds:
  - FSM state encodings (2-bit).
  - HTRANS codes IDLE=0, NONSEQ=2.
  - HBURST SINGLE=0.
  - AXI resp codes OKAY=0, SLVERR=2.
  - The max-size computation macro.
- One natural sub-module: munoc_ahb_slave_ni_rsp_reg, the response holding register with valid/ready handshake and stable-while-stalled semantics.

Test Plan:
- Write, shready=1: req addr=0x100, size=2, wdata=0xDEADBEEF, tid=3 -> shtrans=2 for 1 cycle, then shwdata=0xDEADBEEF; rsp_valid 3 cycles after accept with tid=3, resp=0, rdata=0.
- Read, 2 wait states: read addr=0x204, shready low for 2 DATA cycles, shrdata=0x12345678 -> rsp_rdata=0x12345678, resp=0, rsp_valid 5 cycles after accept.
- AHB error: shresp=1/shready=0, then shresp=1/shready=1 -> resp=2, rdata=0; with the macro defined, err_count 0->1.
- Size error: size=3 with BW_NODE_DATA=32 -> shtrans stays 0; rsp_valid next cycle after accept with resp=2.
- Backpressure and gating: rsp_ready low 4 cycles -> rsp_* stable and req_ready=0 throughout. comm_disable=1 with req_valid=1 in IDLE -> no accept until comm_disable drops.
- Reset mid-DATA: rst=1 -> next cycle shtrans=0, rsp_valid=0, state IDLE; no response emitted.

Source files
------------

// File: rtl/munoc_ahb_slave_network_interface_core_pkg.sv
// Shared encodings for the AHB slave-side NI: FSM states, HTRANS/HBURST codes,
// AXI response codes and the max-transfer-size helper.
package munoc_ahb_slave_network_interface_core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [2:0] HBURST_SINGLE = 3'd0;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    // Largest legal AXI/AHB size code for a data bus of the given width.
    function automatic logic [2:0] max_size(input int bw_data);
        return 3'($clog2(bw_data / 8));
    endfunction

endpackage

// File: rtl/munoc_ahb_slave_network_interface_core_if.sv
// Request/response handshake and AHB-Lite bus bundle. The slave modport is the
// NI core's view; the master modport is the surrounding NoC link and AHB slave.
interface munoc_ahb_slave_network_interface_core_if #(
    parameter int BW_PLATFORM_ADDR = 32,
    parameter int BW_NODE_DATA     = 32,
    parameter int BW_TID           = 4
);
    logic                        req_valid;
    logic                        req_ready;
    logic                        req_write;
    logic [BW_PLATFORM_ADDR-1:0] req_addr;
    logic [2:0]                  req_size;
    logic [3:0]                  req_prot;
    logic [BW_TID-1:0]           req_tid;
    logic [BW_NODE_DATA-1:0]     req_wdata;

    logic                        rsp_valid;
    logic                        rsp_ready;
    logic                        rsp_write;
    logic [BW_TID-1:0]           rsp_tid;
    logic [BW_NODE_DATA-1:0]     rsp_rdata;
    logic [1:0]                  rsp_resp;

    logic [BW_PLATFORM_ADDR-1:0] shaddr;
    logic [2:0]                  shburst;
    logic                        shmasterlock;
    logic [3:0]                  shprot;
    logic [2:0]                  shsize;
    logic [1:0]                  shtrans;
    logic [BW_NODE_DATA-1:0]     shwdata;
    logic                        shwrite;
    logic [BW_NODE_DATA-1:0]     shrdata;
    logic                        shready;
    logic                        shresp;

    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_prot, req_tid, req_wdata,
        output req_ready,
        output rsp_valid, rsp_write, rsp_tid, rsp_rdata, rsp_resp,
        input  rsp_ready,
        output shaddr, shburst, shmasterlock, shprot, shsize, shtrans, shwdata, shwrite,
        input  shrdata, shready, shresp
    );

    modport master (
        output req_valid, req_write, req_addr, req_size, req_prot, req_tid, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_write, rsp_tid, rsp_rdata, rsp_resp,
        output rsp_ready,
        input  shaddr, shburst, shmasterlock, shprot, shsize, shtrans, shwdata, shwrite,
        output shrdata, shready, shresp
    );

endinterface

// File: rtl/munoc_ahb_slave_network_interface_core_rsp_reg.sv
// Response holding register: loads once per transaction and keeps every field
// stable until the consumer takes it with rsp_valid & rsp_ready.
module munoc_ahb_slave_ni_rsp_reg #(
    parameter int BW_NODE_DATA = 32,
    parameter int BW_TID       = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    load_write,
    input  logic [BW_TID-1:0]       load_tid,
    input  logic [BW_NODE_DATA-1:0] load_rdata,
    input  logic [1:0]              load_resp,
    input  logic                    rsp_ready,
    output logic                    rsp_valid,
    output logic                    rsp_write,
    output logic [BW_TID-1:0]       rsp_tid,
    output logic [BW_NODE_DATA-1:0] rsp_rdata,
    output logic [1:0]              rsp_resp
);

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_tid   <= '0;
            rsp_rdata <= '0;
            rsp_resp  <= '0;
        end else if (load) begin
            rsp_valid <= 1'b1;
            rsp_write <= load_write;
            rsp_tid   <= load_tid;
            rsp_rdata <= load_rdata;
            rsp_resp  <= load_resp;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/munoc_ahb_slave_network_interface_core.sv
// AHB slave network interface core: one AHB SINGLE transfer per NoC request.
// Optional SLVERR counter enabled by defining MUNOC_AHB_SLAVE_NI_ERROR_COUNT_EN.
module munoc_ahb_slave_network_interface_core
    import munoc_ahb_slave_network_interface_core_pkg::*;
#(
    parameter int BW_PLATFORM_ADDR = 32,
    parameter int BW_NODE_DATA     = 32,
    parameter int BW_TID           = 4,
    parameter int BW_ERRCNT        = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 comm_disable,
    munoc_ahb_slave_network_interface_core_if.slave bus,
    output logic [BW_ERRCNT-1:0] err_count
);

    localparam logic [2:0] MAX_SIZE = max_size(BW_NODE_DATA);

    state_e                      state;
    logic [BW_PLATFORM_ADDR-1:0] shaddr_q;
    logic [3:0]                  shprot_q;
    logic [2:0]                  shsize_q;
    logic [1:0]                  shtrans_q;
    logic [BW_NODE_DATA-1:0]     shwdata_q;
    logic                        shwrite_q;
    logic [BW_TID-1:0]           lat_tid;
    logic [BW_NODE_DATA-1:0]     lat_wdata;

    logic                        accept;
    logic                        size_err;
    logic                        data_done;
    logic                        rsp_load;
    logic                        rsp_load_write;
    logic [BW_TID-1:0]           rsp_load_tid;
    logic [BW_NODE_DATA-1:0]     rsp_load_rdata;
    logic [1:0]                  rsp_load_resp;

    assign bus.req_ready = (state == ST_IDLE) && !comm_disable && !rst;
    assign accept        = bus.req_valid && bus.req_ready;
    assign size_err      = bus.req_size > MAX_SIZE;
    assign data_done     = (state == ST_DATA) && bus.shready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            shaddr_q  <= '0;
            shprot_q  <= '0;
            shsize_q  <= '0;
            shtrans_q <= HTRANS_IDLE;
            shwdata_q <= '0;
            shwrite_q <= 1'b0;
            lat_tid   <= '0;
            lat_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    lat_tid   <= bus.req_tid;
                    lat_wdata <= bus.req_wdata;
                    // Oversized requests are answered locally; the AHB bus never sees them.
                    if (size_err) begin
                        state <= ST_RESP;
                    end else begin
                        state     <= ST_ADDR;
                        shtrans_q <= HTRANS_NONSEQ;
                        shaddr_q  <= bus.req_addr;
                        shsize_q  <= bus.req_size;
                        shprot_q  <= bus.req_prot;
                        shwrite_q <= bus.req_write;
                    end
                end
                ST_ADDR: if (bus.shready) begin
                    state     <= ST_DATA;
                    shtrans_q <= HTRANS_IDLE;
                    shwdata_q <= shwrite_q ? lat_wdata : '0;
                end
                ST_DATA: if (bus.shready) state <= ST_RESP;
                ST_RESP: if (bus.rsp_valid && bus.rsp_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // HRESP with HREADY low is only the first cycle of a two-cycle error response.
    always_comb begin
        rsp_load       = 1'b0;
        rsp_load_write = shwrite_q;
        rsp_load_tid   = lat_tid;
        rsp_load_rdata = '0;
        rsp_load_resp  = RESP_OKAY;
        if (state == ST_IDLE && accept && size_err) begin
            rsp_load       = 1'b1;
            rsp_load_write = bus.req_write;
            rsp_load_tid   = bus.req_tid;
            rsp_load_resp  = RESP_SLVERR;
        end else if (data_done) begin
            rsp_load       = 1'b1;
            rsp_load_resp  = bus.shresp ? RESP_SLVERR : RESP_OKAY;
            rsp_load_rdata = (!shwrite_q && !bus.shresp) ? bus.shrdata : '0;
        end
    end

    munoc_ahb_slave_ni_rsp_reg #(
        .BW_NODE_DATA (BW_NODE_DATA),
        .BW_TID       (BW_TID)
    ) u_rsp_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (rsp_load),
        .load_write (rsp_load_write),
        .load_tid   (rsp_load_tid),
        .load_rdata (rsp_load_rdata),
        .load_resp  (rsp_load_resp),
        .rsp_ready  (bus.rsp_ready),
        .rsp_valid  (bus.rsp_valid),
        .rsp_write  (bus.rsp_write),
        .rsp_tid    (bus.rsp_tid),
        .rsp_rdata  (bus.rsp_rdata),
        .rsp_resp   (bus.rsp_resp)
    );

    assign bus.shaddr       = shaddr_q;
    assign bus.shburst      = HBURST_SINGLE;
    assign bus.shmasterlock = 1'b0;
    assign bus.shprot       = shprot_q;
    assign bus.shsize       = shsize_q;
    assign bus.shtrans      = shtrans_q;
    assign bus.shwdata      = shwdata_q;
    assign bus.shwrite      = shwrite_q;

`ifdef MUNOC_AHB_SLAVE_NI_ERROR_COUNT_EN
    logic [BW_ERRCNT-1:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            err_cnt_q <= '0;
        else if (bus.rsp_valid && bus.rsp_ready && bus.rsp_resp == RESP_SLVERR && err_cnt_q != '1)
            err_cnt_q <= err_cnt_q + 1'b1;
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_munoc_ahb_slave_network_interface_core.sv
// Directed bench for the AHB slave NI core: write, waited read, AHB error with
// backpressure, size error, comm_disable gating and reset mid-transfer.
module tb_munoc_ahb_slave_network_interface_core;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TW = 4;
    localparam int EW = 8;
`ifdef MUNOC_AHB_SLAVE_NI_ERROR_COUNT_EN
    localparam bit ERRCNT_EN = 1'b1;
`else
    localparam bit ERRCNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          comm_disable;
    logic [EW-1:0] err_count;
    int            n_chk = 0;
    int            n_fail = 0;
    int            exp_err = 0;

    always #5 clk = ~clk;

    munoc_ahb_slave_network_interface_core_if #(
        .BW_PLATFORM_ADDR(AW), .BW_NODE_DATA(DW), .BW_TID(TW)
    ) bus ();

    munoc_ahb_slave_network_interface_core #(
        .BW_PLATFORM_ADDR(AW), .BW_NODE_DATA(DW), .BW_TID(TW), .BW_ERRCNT(EW)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .comm_disable (comm_disable),
        .bus          (bus),
        .err_count    (err_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                             input logic [3:0] prot, input logic [3:0] tid, input logic [31:0] wd);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_size  = size;
        bus.req_prot  = prot;
        bus.req_tid   = tid;
        bus.req_wdata = wd;
    endtask

    initial begin
        rst = 1'b1; comm_disable = 1'b0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_size = '0;
        bus.req_prot = '0; bus.req_tid = '0; bus.req_wdata = '0;
        bus.rsp_ready = 1'b1; bus.shrdata = '0; bus.shready = 1'b1; bus.shresp = 1'b0;
        step(); step(); smp();
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_shtrans",   32'(bus.shtrans), 0);
        chk("rst_shaddr",    bus.shaddr, 0);
        chk("rst_shwdata",   bus.shwdata, 0);
        chk("rst_rsp_tid",   32'(bus.rsp_tid), 0);
        chk("rst_err_count", 32'(err_count), 0);
        rst = 1'b0;
        step(); smp();
        chk("idle_req_ready", 32'(bus.req_ready), 1);

        // Write with shready high throughout
        drive_req(1'b1, 32'h100, 3'd2, 4'd3, 4'd3, 32'hDEADBEEF);
        step(); bus.req_valid = 1'b0; smp();
        chk("wr_shtrans", 32'(bus.shtrans), 2);
        chk("wr_shaddr",  bus.shaddr, 32'h100);
        chk("wr_shwrite", 32'(bus.shwrite), 1);
        chk("wr_shsize",  32'(bus.shsize), 2);
        chk("wr_shprot",  32'(bus.shprot), 3);
        chk("wr_shburst", 32'(bus.shburst), 0);
        chk("wr_req_ready_busy", 32'(bus.req_ready), 0);
        step(); smp();
        chk("wr_data_shtrans", 32'(bus.shtrans), 0);
        chk("wr_shwdata", bus.shwdata, 32'hDEADBEEF);
        chk("wr_rsp_early", 32'(bus.rsp_valid), 0);
        step(); smp();
        chk("wr_rsp_valid", 32'(bus.rsp_valid), 1);
        chk("wr_rsp_tid",   32'(bus.rsp_tid), 3);
        chk("wr_rsp_resp",  32'(bus.rsp_resp), 0);
        chk("wr_rsp_rdata", bus.rsp_rdata, 0);
        chk("wr_rsp_write", 32'(bus.rsp_write), 1);
        step(); smp();
        chk("wr_rsp_done",   32'(bus.rsp_valid), 0);
        chk("wr_idle_ready", 32'(bus.req_ready), 1);

        // Read with two DATA wait states
        drive_req(1'b0, 32'h204, 3'd2, 4'd1, 4'd5, 32'h0BADF00D);
        step(); bus.req_valid = 1'b0; smp();
        chk("rd_shtrans", 32'(bus.shtrans), 2);
        chk("rd_shwrite", 32'(bus.shwrite), 0);
        chk("rd_shaddr",  bus.shaddr, 32'h204);
        step(); bus.shready = 1'b0; smp();
        chk("rd_shwdata", bus.shwdata, 0);
        step(); smp();
        chk("rd_wait1", 32'(bus.rsp_valid), 0);
        step(); bus.shready = 1'b1; bus.shrdata = 32'h12345678; smp();
        chk("rd_wait2", 32'(bus.rsp_valid), 0);
        step(); smp();
        chk("rd_rsp_valid", 32'(bus.rsp_valid), 1);
        chk("rd_rsp_rdata", bus.rsp_rdata, 32'h12345678);
        chk("rd_rsp_resp",  32'(bus.rsp_resp), 0);
        chk("rd_rsp_tid",   32'(bus.rsp_tid), 5);
        chk("rd_rsp_write", 32'(bus.rsp_write), 0);
        step(); bus.shrdata = '0;

        // Two-cycle AHB error, then response backpressure
        bus.rsp_ready = 1'b0;
        drive_req(1'b0, 32'h300, 3'd2, 4'd0, 4'd9, 32'h0);
        step(); bus.req_valid = 1'b0;
        step(); bus.shready = 1'b0; bus.shresp = 1'b1; bus.shrdata = 32'hAAAA5555; smp();
        chk("err_wait1", 32'(bus.rsp_valid), 0);
        step(); bus.shready = 1'b1; smp();
        chk("err_wait2", 32'(bus.rsp_valid), 0);
        step(); bus.shresp = 1'b0; smp();
        chk("err_rsp_valid", 32'(bus.rsp_valid), 1);
        chk("err_rsp_resp",  32'(bus.rsp_resp), 2);
        chk("err_rsp_rdata", bus.rsp_rdata, 0);
        chk("err_rsp_tid",   32'(bus.rsp_tid), 9);
        for (int i = 0; i < 4; i++) begin
            step(); smp();
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 1);
            chk("bp_rsp_resp",  32'(bus.rsp_resp), 2);
            chk("bp_rsp_tid",   32'(bus.rsp_tid), 9);
            chk("bp_rsp_rdata", bus.rsp_rdata, 0);
            chk("bp_req_ready", 32'(bus.req_ready), 0);
        end
        chk("err_cnt_before", 32'(err_count), 32'(exp_err));
        bus.rsp_ready = 1'b1;
        step(); smp();
        if (ERRCNT_EN) exp_err = 1;
        chk("err_rsp_done", 32'(bus.rsp_valid), 0);
        chk("err_cnt_after", 32'(err_count), 32'(exp_err));

        // Size error: size 3 on a 32-bit bus
        drive_req(1'b1, 32'h400, 3'd3, 4'd0, 4'd7, 32'h55);
        step(); bus.req_valid = 1'b0; smp();
        chk("sz_shtrans",   32'(bus.shtrans), 0);
        chk("sz_shaddr",    bus.shaddr, 32'h300);
        chk("sz_rsp_valid", 32'(bus.rsp_valid), 1);
        chk("sz_rsp_resp",  32'(bus.rsp_resp), 2);
        chk("sz_rsp_tid",   32'(bus.rsp_tid), 7);
        chk("sz_rsp_rdata", bus.rsp_rdata, 0);
        chk("sz_rsp_write", 32'(bus.rsp_write), 1);
        step(); smp();
        if (ERRCNT_EN) exp_err = 2;
        chk("sz_rsp_done",  32'(bus.rsp_valid), 0);
        chk("sz_err_count", 32'(err_count), 32'(exp_err));

        // comm_disable gates acceptance only
        comm_disable = 1'b1;
        drive_req(1'b1, 32'h500, 3'd0, 4'd2, 4'd1, 32'hA5);
        smp();
        chk("cd_req_ready", 32'(bus.req_ready), 0);
        step(); step(); smp();
        chk("cd_shtrans_blocked", 32'(bus.shtrans), 0);
        chk("cd_rsp_blocked",     32'(bus.rsp_valid), 0);
        comm_disable = 1'b0; #1;
        chk("cd_release_ready", 32'(bus.req_ready), 1);
        step(); bus.req_valid = 1'b0; comm_disable = 1'b1; smp();
        chk("cd_shtrans", 32'(bus.shtrans), 2);
        chk("cd_shaddr",  bus.shaddr, 32'h500);
        chk("cd_shsize",  32'(bus.shsize), 0);
        step(); smp();
        chk("cd_shwdata", bus.shwdata, 32'hA5);
        step(); smp();
        chk("cd_rsp_valid", 32'(bus.rsp_valid), 1);
        chk("cd_rsp_tid",   32'(bus.rsp_tid), 1);
        step(); comm_disable = 1'b0; smp();
        chk("cd_rsp_done", 32'(bus.rsp_valid), 0);

        // Reset while in DATA: transfer dropped, no response
        drive_req(1'b0, 32'h600, 3'd2, 4'd0, 4'd2, 32'h0);
        step(); bus.req_valid = 1'b0;
        step(); bus.shready = 1'b0;
        step(); smp();
        chk("rm_in_data_rsp", 32'(bus.rsp_valid), 0);
        chk("rm_in_data_addr", bus.shaddr, 32'h600);
        rst = 1'b1;
        step(); rst = 1'b0; bus.shready = 1'b1; smp();
        chk("rm_shtrans",   32'(bus.shtrans), 0);
        chk("rm_shaddr",    bus.shaddr, 0);
        chk("rm_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rm_req_ready", 32'(bus.req_ready), 1);
        chk("rm_err_count", 32'(err_count), 0);
        for (int i = 0; i < 3; i++) begin
            step(); smp();
            chk("rm_no_rsp", 32'(bus.rsp_valid), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
